// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-bit shift-add multiplier among N requesters.
// Latches the winner's operands, pulses mul_init, waits for done (with timeout), then acks.
module mult_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 40
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [4*N-1:0] md_in,
  input  logic [4*N-1:0] mr_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [7:0]     pp_out,
  output logic           err,
  output logic           busy,
  output logic           mul_init,
  output logic [3:0]     mul_md,
  output logic [3:0]     mul_mr,
  input  logic [7:0]     mul_pp,
  input  logic           mul_done
);

  localparam int unsigned NU = N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_INIT,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [7:0]     pp_q, pp_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           init_q, init_d;
  logic [3:0]     md_q, md_d;
  logic [3:0]     mr_q, mr_d;

  logic           win_found;
  logic [IW-1:0]  win_idx;
  logic [IW-1:0]  ptr_next;

  // First requester at or above the pointer, wrapping N-1 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      int unsigned pos;
      pos = (32'(ptr_q) + i) % NU;
      if (!win_found && req[pos]) begin
        win_found = 1'b1;
        win_idx   = IW'(pos);
      end
    end
  end

  assign ptr_next = IW'((32'(idx_q) + 32'd1) % NU);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    pp_d    = pp_q;
    err_d   = err_q;
    busy_d  = busy_q;
    init_d  = 1'b0;
    md_d    = md_q;
    mr_d    = mr_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          idx_d   = win_idx;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
          md_d    = md_in[32'(win_idx)*4 +: 4];
          mr_d    = mr_in[32'(win_idx)*4 +: 4];
          busy_d  = 1'b1;
        end
      end
      S_GRANT: begin
        state_d = S_INIT;
        init_d  = 1'b1;
      end
      S_INIT: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A done arriving on the same cycle the budget expires still counts as success.
        if (mul_done) begin
          state_d = S_RESP;
          pp_d    = mul_pp;
          err_d   = 1'b0;
          ack_d   = gnt_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          pp_d    = '0;
          err_d   = 1'b1;
          ack_d   = gnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ptr_d   = ptr_next;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      pp_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
      md_q    <= '0;
      mr_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      pp_q    <= pp_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      init_q  <= init_d;
      md_q    <= md_d;
      mr_q    <= mr_d;
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign pp_out   = pp_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign mul_init = init_q;
  assign mul_md   = md_q;
  assign mul_mr   = mr_q;

endmodule
